fwrisc_regfile_ctrl: RTL and testbench

Sequencer and arbiter in front of `fwrisc_regfile`. After reset, zero-fills every register entry, because the FPGA block-RAM build has no reset. Afterwards, shares the regfile's single write port and read port A between the core pipeline and a debug requester (UART debug monitor). Enforces r0 == 0 on every write path. Sits between the core's decode/writeback stages and the regfile instance.

---
 rtl/fwrisc_regfile_ctrl_pkg.sv | 17 +
 rtl/fwrisc_regfile_ctrl.sv | 153 +++++++++++++++
 tb/tb_fwrisc_regfile_ctrl.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fwrisc_regfile_ctrl_pkg.sv
// Shared types and default geometry for the regfile init sequencer / debug arbiter.
package fwrisc_regfile_ctrl_pkg;

   localparam int unsigned RF_NUM_REGS = 64;
   localparam int unsigned RF_AW       = 6;
   localparam int unsigned RF_DW       = 32;

   typedef enum logic [2:0] {
      INIT   = 3'd0,
      IDLE   = 3'd1,
      DBG_WR = 3'd2,
      DBG_RA = 3'd3,
      DBG_RD = 3'd4,
      ACK    = 3'd5
   } regfile_ctrl_state_e;

endpackage

// File: rtl/fwrisc_regfile_ctrl.sv
// Zero-fills the regfile after reset, then arbitrates its write port and read port A
// between the core pipeline and the debug monitor, keeping r0 hard-wired to zero.
module fwrisc_regfile_ctrl
   import fwrisc_regfile_ctrl_pkg::*;
#(
   parameter int unsigned   NUM_REGS = RF_NUM_REGS,
   parameter int unsigned   AW       = RF_AW,
   parameter int unsigned   DW       = RF_DW,
   parameter logic [DW-1:0] INIT_VAL = '0
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [AW-1:0]       core_ra_raddr,
   input  logic [AW-1:0]       core_rb_raddr,
   input  logic [AW-1:0]       core_rd_waddr,
   input  logic [DW-1:0]       core_rd_wdata,
   input  logic                core_rd_wen,
   output logic                core_stall,
   output logic                init_done,
   input  logic                dbg_req,
   input  logic                dbg_we,
   input  logic [AW-1:0]       dbg_addr,
   input  logic [DW-1:0]       dbg_wdata,
   output logic                dbg_ack,
   output logic [DW-1:0]       dbg_rdata,
   output logic [AW-1:0]       rf_ra_raddr,
   output logic [AW-1:0]       rf_rb_raddr,
   output logic [AW-1:0]       rf_rd_waddr,
   output logic [DW-1:0]       rf_rd_wdata,
   output logic                rf_rd_wen,
   input  logic [DW-1:0]       rf_ra_rdata,
   output regfile_ctrl_state_e fsm_state
);

   localparam logic [AW-1:0] LAST_IDX = AW'(NUM_REGS - 1);

   regfile_ctrl_state_e state_q, state_d;
   logic [AW-1:0]       idx_q, idx_d;
   logic                init_done_q, init_done_d;
   logic [DW-1:0]       dbg_rdata_q, dbg_rdata_d;

   logic init_wr;
   logic dbg_wr_issue;
   logic ra_sel_dbg;
   logic stall;
   logic ack;
   logic wen_req;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= INIT;
         idx_q       <= '0;
         init_done_q <= 1'b0;
         dbg_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         init_done_q <= init_done_d;
         dbg_rdata_q <= dbg_rdata_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      init_done_d  = init_done_q;
      dbg_rdata_d  = dbg_rdata_q;
      init_wr      = 1'b0;
      dbg_wr_issue = 1'b0;
      ra_sel_dbg   = 1'b0;
      stall        = 1'b0;
      ack          = 1'b0;

      unique case (state_q)
         INIT: begin
            init_wr = 1'b1;
            stall   = 1'b1;
            idx_d   = idx_q + AW'(1);
            if (idx_q == LAST_IDX) begin
               idx_d       = '0;
               init_done_d = 1'b1;
               state_d     = IDLE;
            end
         end
         IDLE: begin
            if (dbg_req) begin
               state_d = dbg_we ? DBG_WR : DBG_RA;
            end
         end
         DBG_WR: begin
            // The core owns the write port whenever it wants it; debug retries next cycle.
            if (!core_rd_wen) begin
               dbg_wr_issue = 1'b1;
               state_d      = ACK;
            end
         end
         DBG_RA: begin
            ra_sel_dbg = 1'b1;
            stall      = 1'b1;
            state_d    = DBG_RD;
         end
         DBG_RD: begin
            // Port A is handed back now so the core's read data is valid again at ACK.
            stall       = 1'b1;
            dbg_rdata_d = rf_ra_rdata;
            state_d     = ACK;
         end
         ACK: begin
            ack     = 1'b1;
            state_d = IDLE;
         end
         default: begin
            state_d = INIT;
         end
      endcase
   end

   always_comb begin
      rf_rd_waddr = core_rd_waddr;
      rf_rd_wdata = core_rd_wdata;
      wen_req     = core_rd_wen;
      if (init_wr) begin
         rf_rd_waddr = idx_q;
         rf_rd_wdata = INIT_VAL;
         wen_req     = 1'b1;
      end else if (dbg_wr_issue) begin
         rf_rd_waddr = dbg_addr;
         rf_rd_wdata = dbg_wdata;
         wen_req     = 1'b1;
      end
   end

   // r0 is only ever written by the zero-fill; every other path to it is dropped.
   always_comb begin
      rf_rd_wen = 1'b0;
      if (!reset) begin
         if (init_wr) begin
            rf_rd_wen = 1'b1;
         end else begin
            rf_rd_wen = wen_req && (rf_rd_waddr != '0);
         end
      end
   end

   assign rf_ra_raddr = ra_sel_dbg ? dbg_addr : core_ra_raddr;
   assign rf_rb_raddr = core_rb_raddr;
   assign core_stall  = reset || stall;
   assign dbg_ack     = ack && !reset;
   assign init_done   = init_done_q && !reset;
   assign dbg_rdata   = dbg_rdata_q;
   assign fsm_state   = state_q;

endmodule

// File: tb/tb_fwrisc_regfile_ctrl.sv
// Directed plus randomized bench for fwrisc_regfile_ctrl with a behavioural regfile and
// a register-map reference model.
module tb_fwrisc_regfile_ctrl;
   import fwrisc_regfile_ctrl_pkg::*;

   localparam int NUM_REGS = 64;
   localparam int AW       = 6;
   localparam int DW       = 32;

   logic                clock = 1'b0;
   logic                reset = 1'b1;
   logic [AW-1:0]       core_ra_raddr, core_rb_raddr, core_rd_waddr;
   logic [DW-1:0]       core_rd_wdata;
   logic                core_rd_wen;
   logic                core_stall, init_done;
   logic                dbg_req, dbg_we;
   logic [AW-1:0]       dbg_addr;
   logic [DW-1:0]       dbg_wdata;
   logic                dbg_ack;
   logic [DW-1:0]       dbg_rdata;
   logic [AW-1:0]       rf_ra_raddr, rf_rb_raddr, rf_rd_waddr;
   logic [DW-1:0]       rf_rd_wdata;
   logic                rf_rd_wen;
   logic [DW-1:0]       rf_ra_rdata = '0;
   regfile_ctrl_state_e fsm_state;

   logic [DW-1:0] rf_mem  [NUM_REGS];
   logic [DW-1:0] exp_mem [NUM_REGS];
   logic [DW-1:0] exp_rdata;
   int tests_run    = 0;
   int tests_failed = 0;
   int r0_viol      = 0;

   fwrisc_regfile_ctrl #(
      .NUM_REGS(NUM_REGS), .AW(AW), .DW(DW), .INIT_VAL('0)
   ) dut (
      .clock(clock), .reset(reset),
      .core_ra_raddr(core_ra_raddr), .core_rb_raddr(core_rb_raddr),
      .core_rd_waddr(core_rd_waddr), .core_rd_wdata(core_rd_wdata), .core_rd_wen(core_rd_wen),
      .core_stall(core_stall), .init_done(init_done),
      .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
      .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
      .rf_ra_raddr(rf_ra_raddr), .rf_rb_raddr(rf_rb_raddr), .rf_rd_waddr(rf_rd_waddr),
      .rf_rd_wdata(rf_rd_wdata), .rf_rd_wen(rf_rd_wen), .rf_ra_rdata(rf_ra_rdata),
      .fsm_state(fsm_state)
   );

   always #5 clock = ~clock;

   // Behavioural block RAM: one write port, registered read on port A.
   always @(posedge clock) begin
      if (rf_rd_wen) rf_mem[rf_rd_waddr] <= rf_rd_wdata;
      rf_ra_rdata <= rf_mem[rf_ra_raddr];
   end

   always @(negedge clock) begin
      if (!reset && init_done && rf_rd_wen && rf_rd_waddr == '0) r0_viol++;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic to_sample();
      @(negedge clock);
   endtask

   task automatic to_drive();
      @(posedge clock);
      #1;
   endtask

   task automatic quiet_inputs();
      core_ra_raddr = '0; core_rb_raddr = '0; core_rd_waddr = '0;
      core_rd_wdata = '0; core_rd_wen = 1'b0;
      dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
   endtask

   task automatic noise_inputs();
      core_ra_raddr = AW'($urandom); core_rb_raddr = AW'($urandom);
      core_rd_waddr = AW'($urandom); core_rd_wdata = $urandom;
      core_rd_wen = 1'($urandom_range(0, 1));
      dbg_req = 1'($urandom_range(0, 1)); dbg_we = 1'($urandom_range(0, 1));
      dbg_addr = AW'($urandom); dbg_wdata = $urandom;
   endtask

   // Called in the drive phase of the first cycle after reset is released.
   task automatic run_init(input int abort_at);
      exp_rdata = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         noise_inputs();
         if (i == abort_at) begin
            reset = 1'b1;
            to_sample();
            check("abort_wen", DW'(rf_rd_wen), DW'(0));
            check("abort_stall", DW'(core_stall), DW'(1));
            to_drive();
            reset = 1'b0;
            return;
         end
         to_sample();
         check("init_wen", DW'(rf_rd_wen), DW'(1));
         check("init_waddr", DW'(rf_rd_waddr), DW'(i));
         check("init_wdata", rf_rd_wdata, DW'(0));
         check("init_stall", DW'(core_stall), DW'(1));
         check("init_done_lo", DW'(init_done), DW'(0));
         check("init_ack", DW'(dbg_ack), DW'(0));
         to_drive();
      end
      quiet_inputs();
      to_sample();
      check("init_done_hi", DW'(init_done), DW'(1));
      check("idle_stall", DW'(core_stall), DW'(0));
      to_drive();
      for (int a = 0; a < NUM_REGS; a++) exp_mem[a] = '0;
   endtask

   task automatic dbg_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                            input int n_core, input logic [AW-1:0] caddr);
      logic [DW-1:0] cdata;
      dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = addr; dbg_wdata = data;
      core_rd_wen = 1'b0; core_rb_raddr = AW'($urandom);
      to_sample();
      check("wr_req_stall", DW'(core_stall), DW'(0));
      check("wr_req_ack", DW'(dbg_ack), DW'(0));
      check("rb_pass", DW'(rf_rb_raddr), DW'(core_rb_raddr));
      to_drive();
      for (int k = 0; k < n_core; k++) begin
         cdata = $urandom;
         core_rd_wen = 1'b1; core_rd_waddr = caddr; core_rd_wdata = cdata;
         to_sample();
         check("coll_core_wen", DW'(rf_rd_wen), DW'(caddr != '0));
         if (caddr != '0) begin
            check("coll_core_waddr", DW'(rf_rd_waddr), DW'(caddr));
            check("coll_core_wdata", rf_rd_wdata, cdata);
         end
         check("coll_stall", DW'(core_stall), DW'(0));
         check("coll_ack", DW'(dbg_ack), DW'(0));
         to_drive();
         if (caddr != '0) exp_mem[caddr] = cdata;
      end
      core_rd_wen = 1'b0;
      to_sample();
      check("wr_issue_wen", DW'(rf_rd_wen), DW'(addr != '0));
      if (addr != '0) begin
         check("wr_issue_waddr", DW'(rf_rd_waddr), DW'(addr));
         check("wr_issue_wdata", rf_rd_wdata, data);
      end
      check("wr_issue_stall", DW'(core_stall), DW'(0));
      check("wr_issue_ack", DW'(dbg_ack), DW'(0));
      to_drive();
      if (addr != '0) exp_mem[addr] = data;
      to_sample();
      check("wr_ack", DW'(dbg_ack), DW'(1));
      check("wr_ack_stall", DW'(core_stall), DW'(0));
      check("wr_ack_nowen", DW'(rf_rd_wen), DW'(0));
      check("wr_rdata_held", dbg_rdata, exp_rdata);
      to_drive();
      dbg_req = 1'b0;
      to_sample();
      check("wr_post_ack", DW'(dbg_ack), DW'(0));
      check("wr_post_wen", DW'(rf_rd_wen), DW'(0));
      to_drive();
   endtask

   task automatic dbg_read(input logic [AW-1:0] addr, input logic [AW-1:0] cra);
      logic [AW-1:0] cw;
      logic [DW-1:0] cdata;
      do cw = AW'($urandom_range(1, NUM_REGS - 1)); while (cw == addr || cw == cra);
      dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = addr; core_ra_raddr = cra; core_rd_wen = 1'b0;
      to_sample();
      check("rd_req_stall", DW'(core_stall), DW'(0));
      check("rd_req_raddr", DW'(rf_ra_raddr), DW'(cra));
      to_drive();
      cdata = $urandom;
      core_rd_wen = 1'b1; core_rd_waddr = cw; core_rd_wdata = cdata;
      to_sample();
      check("rd_ra_stall", DW'(core_stall), DW'(1));
      check("rd_ra_raddr", DW'(rf_ra_raddr), DW'(addr));
      check("rd_ra_core_wen", DW'(rf_rd_wen), DW'(1));
      check("rd_ra_core_waddr", DW'(rf_rd_waddr), DW'(cw));
      check("rd_ra_core_wdata", rf_rd_wdata, cdata);
      check("rd_ra_ack", DW'(dbg_ack), DW'(0));
      to_drive();
      exp_mem[cw] = cdata;
      core_rd_wen = 1'b0;
      to_sample();
      check("rd_rd_stall", DW'(core_stall), DW'(1));
      check("rd_rd_raddr", DW'(rf_ra_raddr), DW'(cra));
      check("rd_rd_ack", DW'(dbg_ack), DW'(0));
      to_drive();
      exp_rdata = exp_mem[addr];
      to_sample();
      check("rd_ack", DW'(dbg_ack), DW'(1));
      check("rd_rdata", dbg_rdata, exp_rdata);
      check("rd_core_sees", rf_ra_rdata, exp_mem[cra]);
      check("rd_ack_stall", DW'(core_stall), DW'(0));
      to_drive();
      dbg_req = 1'b0;
      to_sample();
      check("rd_post_ack", DW'(dbg_ack), DW'(0));
      check("rd_post_stall", DW'(core_stall), DW'(0));
      check("rd_rdata_held", dbg_rdata, exp_rdata);
      to_drive();
   endtask

   initial begin
      quiet_inputs();
      exp_rdata = '0;
      to_sample();
      check("rst_stall", DW'(core_stall), DW'(1));
      check("rst_init_done", DW'(init_done), DW'(0));
      check("rst_ack", DW'(dbg_ack), DW'(0));
      check("rst_rdata", dbg_rdata, DW'(0));
      check("rst_wen", DW'(rf_rd_wen), DW'(0));
      check("rst_state", DW'(fsm_state), DW'(INIT));
      to_drive();
      reset = 1'b0;
      run_init(-1);

      dbg_write(6'd5, 32'hDEADBEEF, 0, 6'd0);
      dbg_read(6'd5, 6'd1);

      dbg_write(6'd7, 32'h0000_7777, 3, 6'd3);
      dbg_read(6'd7, 6'd3);
      dbg_read(6'd3, 6'd7);

      core_rd_wen = 1'b1; core_rd_waddr = '0; core_rd_wdata = 32'h1;
      to_sample();
      check("r0_core_wen", DW'(rf_rd_wen), DW'(0));
      to_drive();
      core_rd_wen = 1'b0;
      dbg_write(6'd0, 32'h2, 1, 6'd0);
      dbg_read(6'd0, 6'd5);

      dbg_write(6'd9, 32'h55, 0, 6'd0);
      dbg_write(6'd10, 32'hAA, 0, 6'd0);
      dbg_read(6'd10, 6'd9);

      for (int n = 0; n < 40; n++) begin
         if ($urandom_range(0, 1) == 1)
            dbg_write(AW'($urandom), $urandom, $urandom_range(0, 3), AW'($urandom));
         else
            dbg_read(AW'($urandom), AW'($urandom));
      end
      for (int a = 0; a < NUM_REGS; a++) dbg_read(AW'(a), AW'($urandom));

      reset = 1'b1;
      to_drive();
      reset = 1'b0;
      run_init(30);
      run_init(-1);
      dbg_write(6'd12, 32'h1234_5678, 0, 6'd0);
      dbg_read(6'd12, 6'd2);

      dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 6'd12;
      to_drive();
      to_drive();
      reset = 1'b1;
      to_sample();
      check("rst_rd_ack", DW'(dbg_ack), DW'(0));
      to_drive();
      check("rst_rd_rdata", dbg_rdata, DW'(0));
      reset = 1'b0;
      run_init(-1);
      check("refill_rdata", dbg_rdata, DW'(0));
      dbg_read(6'd12, 6'd5);

      check("r0_never", DW'(r0_viol), DW'(0));
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
